// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
package ifetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage signal bundle: PC register side, instruction memory bus, decode handshake.
interface ifetch_unit_if #(
  parameter int unsigned XLEN = ifetch_unit_pkg::XLEN
) ();

  logic [XLEN-1:0] pc;
  logic            pc_stall;
  logic            flush;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;

  modport master (
    input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output pc_stall, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  pc_stall, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );

endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Synchronous FIFO with clear and a registered head word.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    rd_d    = rd_q + PTR_W'(do_pop);
    wr_d    = wr_q + PTR_W'(do_push);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    // Head is pre-computed for the next cycle; a push landing on the new read slot bypasses the array.
    head_d  = (do_push && (wr_q == rd_d)) ? din_i : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: credit-limited in-order imem requests, PC tagging, decode buffer, flush discard.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  ifetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0]   live_q, live_d, drop_q, drop_d;
  logic [CNT_W-1:0]   out_count, tag_count, pending;
  logic [CNT_W+1:0]   occupancy;
  logic               can_issue, fire, rsp_keep, rsp_drop, out_pop;
  logic               out_empty, out_full, tag_empty, tag_full;
  logic [XLEN-1:0]    tag_head;
  logic [2*XLEN-1:0]  out_head_flat;
  fetch_entry_t       out_din, out_head;

  always_comb begin
    occupancy = {2'b00, live_q} + {2'b00, drop_q} + {2'b00, out_count};
    can_issue = !rst && !bus.flush && (occupancy < (CNT_W+2)'(DEPTH));
    fire      = can_issue && bus.imem_req_ready;
    rsp_drop  = bus.imem_rsp_valid && (drop_q != '0);
    rsp_keep  = bus.imem_rsp_valid && (drop_q == '0) && (live_q != '0) && !bus.flush;
    out_pop   = !out_empty && bus.id_ready;
    pending   = live_q + drop_q;
    out_din   = '{pc: tag_head, instr: bus.imem_rsp_data};
    out_head  = fetch_entry_t'(out_head_flat);

    // On flush every outstanding request becomes stale, minus one answered this very cycle.
    if (bus.flush) begin
      live_d = '0;
      drop_d = (bus.imem_rsp_valid && (pending != '0)) ? pending - 1'b1 : pending;
    end else begin
      live_d = live_q + CNT_W'(fire) - CNT_W'(rsp_keep);
      drop_d = drop_q - CNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      drop_q <= '0;
    end else begin
      live_q <= live_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.flush),
    .push_i  (fire),
    .din_i   (bus.pc),
    .pop_i   (rsp_keep),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_out_q (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.flush),
    .push_i  (rsp_keep),
    .din_i   (out_din),
    .pop_i   (out_pop),
    .head_o  (out_head_flat),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  assign bus.imem_req_valid = can_issue;
  assign bus.imem_req_addr  = bus.pc;
  assign bus.pc_stall       = !rst && !bus.flush && !fire;
  assign bus.if_valid       = !rst && !out_empty;
  assign bus.if_pc          = rst ? '0 : out_head.pc;
  assign bus.if_instr       = rst ? '0 : out_head.instr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.imem_rsp_valid && (live_q == '0) && (drop_q == '0)));
      assert (occupancy <= (CNT_W+2)'(DEPTH));
      assert (tag_count == live_q);
      assert (!(rsp_keep && (out_full || tag_empty)));
      assert (!(fire && tag_full));
    end
  end

endmodule
